// File: rtl/cpu_run_ctrl_if.sv
// Run/step/breakpoint control bus between the CPU run controller and its environment.
// The controller side (master) samples the switches and the PC and drives the clock enable and the status.
interface cpu_run_ctrl_if;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_in;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] tick_count;

    modport master (
        input  run_sw, step_btn, bp_en, bp_addr, pc_in,
        output cpu_ce, state, bp_hit, tick_count
    );

    modport slave (
        output run_sw, step_btn, bp_en, bp_addr, pc_in,
        input  cpu_ce, state, bp_hit, tick_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: free-run with a prescaled clock enable, debounced single-step, PC breakpoint.
// All outputs are registered; the switch and button inputs are synchronized before use.
module cpu_run_ctrl #(
    parameter int DIVIDE_BY       = 5000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic          clk100MHz,
    input  logic          rst_n,
    cpu_run_ctrl_if.master bus
);
    localparam int PW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIVIDE_BY - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT  = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        BREAK = 2'b11
    } state_t;

    logic [1:0] raw_in;
    logic [1:0] sync_in;
    logic       run_sync;
    logic       step_sync;

    assign raw_in    = {bus.step_btn, bus.run_sw};
    assign run_sync  = sync_in[0];
    assign step_sync = sync_in[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;
        always_ff @(posedge clk100MHz or negedge rst_n) begin
            if (!rst_n) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= raw_in[gi];
                sync_reg <= meta_reg;
            end
        end
        assign sync_in[gi] = sync_reg;
    end

    // Debounce: the level follows step_sync only after it has differed for DEBOUNCE_CYCLES cycles.
    logic [DW-1:0] db_cnt_reg;
    logic          db_level_reg;
    logic          step_pulse_reg;

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_reg     <= '0;
            db_level_reg   <= 1'b0;
            step_pulse_reg <= 1'b0;
        end else if (step_sync != db_level_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                db_cnt_reg     <= '0;
                db_level_reg   <= step_sync;
                step_pulse_reg <= step_sync;
            end else begin
                db_cnt_reg     <= db_cnt_reg + 1'b1;
                step_pulse_reg <= 1'b0;
            end
        end else begin
            db_cnt_reg     <= '0;
            step_pulse_reg <= 1'b0;
        end
    end

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          cpu_ce_reg, cpu_ce_next;
    logic          bp_hit_reg;
    logic [31:0]   tick_count_reg;
    logic          bp_match;

    assign bp_match = bus.bp_en && (bus.pc_in == bus.bp_addr);

    always_comb begin
        state_next  = state_reg;
        presc_next  = presc_reg;
        cpu_ce_next = 1'b0;
        unique case (state_reg)
            HALT: begin
                // A run request wins over a simultaneous step, which is dropped.
                if (run_sync) begin
                    state_next = RUN;
                    presc_next = '0;
                end else if (step_pulse_reg) begin
                    state_next  = STEP;
                    cpu_ce_next = 1'b1;
                end
            end
            RUN: begin
                if (!run_sync) begin
                    state_next = HALT;
                end else if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    if (bp_match) state_next  = BREAK;
                    else          cpu_ce_next = 1'b1;
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            STEP: begin
                state_next = HALT;
            end
            BREAK: begin
                if (!run_sync) begin
                    state_next = HALT;
                end else if (step_pulse_reg) begin
                    state_next  = STEP;
                    cpu_ce_next = 1'b1;
                end
            end
            default: state_next = HALT;
        endcase
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HALT;
            presc_reg      <= '0;
            cpu_ce_reg     <= 1'b0;
            bp_hit_reg     <= 1'b0;
            tick_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            cpu_ce_reg <= cpu_ce_next;
            bp_hit_reg <= (state_next == BREAK);
            if (cpu_ce_reg) tick_count_reg <= tick_count_reg + 32'd1;
        end
    end

    assign bus.cpu_ce     = cpu_ce_reg;
    assign bus.state      = state_reg;
    assign bus.bp_hit     = bp_hit_reg;
    assign bus.tick_count = tick_count_reg;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed vector table, multi-cycle corner sequences and a random run
// checked every cycle against a behavioural model of the run/step/break rules.
module tb_cpu_run_ctrl;
    localparam int DIV = 4;
    localparam int DB  = 8;

    logic clk100MHz = 1'b0;
    logic rst_n     = 1'b0;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(.DIVIDE_BY(DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk100MHz = ~clk100MHz;

    int checks   = 0;
    int failures = 0;
    string cur_tag = "init";

    // Behavioural model: modes 0 halt, 1 run, 2 step, 3 break
    int          m_rq[$];
    int          m_sq[$];
    int          m_level, m_last_ss, m_runlen, m_pulse, m_mode, m_cir, m_ce;
    logic [31:0] m_tick;

    function automatic void model_reset();
        m_rq = {};
        m_sq = {};
        m_rq.push_back(0); m_rq.push_back(0);
        m_sq.push_back(0); m_sq.push_back(0);
        m_level = 0; m_last_ss = 0; m_runlen = 0; m_pulse = 0;
        m_mode = 0; m_cir = 0; m_ce = 0; m_tick = 32'd0;
    endfunction

    function automatic void model_edge();
        int rs, ss, np, nce;
        bit bp;
        rs = m_rq.pop_front();
        m_rq.push_back(int'(bus.run_sw));
        ss = m_sq.pop_front();
        m_sq.push_back(int'(bus.step_btn));
        bp = bus.bp_en && (bus.pc_in == bus.bp_addr);
        if (ss == m_last_ss) m_runlen++;
        else begin
            m_runlen  = 1;
            m_last_ss = ss;
        end
        np = 0;
        if (ss != m_level && m_runlen >= DB) begin
            m_level = ss;
            np      = ss;
        end
        nce = 0;
        case (m_mode)
            0: if (rs != 0) begin m_mode = 1; m_cir = 0; end
               else if (m_pulse != 0) begin m_mode = 2; nce = 1; end
            1: if (rs == 0) m_mode = 0;
               else begin
                   if ((m_cir % DIV) == DIV - 1) begin
                       if (bp) m_mode = 3;
                       else    nce = 1;
                   end
                   m_cir++;
               end
            2: m_mode = 0;
            default: if (rs == 0) m_mode = 0;
                     else if (m_pulse != 0) begin m_mode = 2; nce = 1; end
        endcase
        m_tick  = m_tick + 32'(m_ce);
        m_ce    = nce;
        m_pulse = np;
    endfunction

    task automatic compare_model();
        logic [1:0] es;
        es = 2'(m_mode);
        checks++;
        if (bus.cpu_ce !== 1'(m_ce) || bus.state !== es ||
            bus.bp_hit !== (m_mode == 3) || bus.tick_count !== m_tick) begin
            failures++;
            $display("FAIL %s t=%0t: got ce=%b state=%b bp_hit=%b tick=%h, want ce=%0d state=%b bp_hit=%0d tick=%h",
                     cur_tag, $time, bus.cpu_ce, bus.state, bus.bp_hit, bus.tick_count,
                     m_ce, es, (m_mode == 3), m_tick);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk100MHz);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        run;
        logic        step;
        logic        bpen;
        logic [31:0] pc;
        int          cycles;
        logic [1:0]  exp_state;
        logic [31:0] exp_tick;
        logic        exp_bp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int ce_cnt, enter_idx, ce_idx, found;
        bit saw_step;
        logic [31:0] base;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,  5,  2'b00, 32'd0,  1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0,  40, 2'b01, 32'd9,  1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,  4,  2'b00, 32'd9,  1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h10, 10, 2'b11, 32'd9,  1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h10, 20, 2'b11, 32'd9,  1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 12, 2'b00, 32'd10, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h10, 12, 2'b00, 32'd10, 1'b0};

        bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.bp_en = 1'b0;
        bus.bp_addr = 32'h10; bus.pc_in = 32'h0;
        model_reset();
        #1;
        cur_tag = "reset";
        compare_model();
        repeat (3) cycle();
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            cur_tag = $sformatf("vec%0d", v);
            bus.run_sw = tbl[v].run; bus.step_btn = tbl[v].step;
            bus.bp_en = tbl[v].bpen; bus.pc_in = tbl[v].pc;
            for (int c = 0; c < tbl[v].cycles; c++) cycle();
            check_val($sformatf("vec%0d_state", v), 32'(bus.state), 32'(tbl[v].exp_state));
            check_val($sformatf("vec%0d_tick", v), bus.tick_count, tbl[v].exp_tick);
            check_val($sformatf("vec%0d_bp_hit", v), 32'(bus.bp_hit), 32'(tbl[v].exp_bp));
            $display("vec %0d: run=%b step=%b bp_en=%b pc=%h cycles=%0d -> state=%b tick=%0d",
                     v, tbl[v].run, tbl[v].step, tbl[v].bpen, tbl[v].pc, tbl[v].cycles,
                     bus.state, bus.tick_count);
        end

        // Bouncing button then a clean hold: exactly one step
        cur_tag = "bounce";
        bus.bp_en = 1'b0; bus.run_sw = 1'b0;
        base = m_tick; ce_cnt = 0; saw_step = 0;
        for (int i = 0; i < 8; i++) begin
            bus.step_btn = (i % 2 == 0);
            repeat (3) begin cycle(); ce_cnt += int'(bus.cpu_ce); if (bus.state == 2'b10) saw_step = 1; end
        end
        bus.step_btn = 1'b1;
        repeat (12) begin cycle(); ce_cnt += int'(bus.cpu_ce); if (bus.state == 2'b10) saw_step = 1; end
        bus.step_btn = 1'b0;
        repeat (14) begin cycle(); ce_cnt += int'(bus.cpu_ce); if (bus.state == 2'b10) saw_step = 1; end
        check_val("bounce_ce_count", 32'(ce_cnt), 32'd1);
        check_val("bounce_tick", bus.tick_count, base + 32'd1);
        check_val("bounce_saw_step", 32'(saw_step), 32'd1);
        check_val("bounce_end_state", 32'(bus.state), 32'd0);
        $display("bounce: ce pulses=%0d tick=%0d", ce_cnt, bus.tick_count);

        // Run request and step edge seen in the same HALT cycle
        cur_tag = "simul";
        bus.step_btn = 1'b1;
        repeat (8) cycle();
        bus.run_sw = 1'b1;
        enter_idx = -1; ce_idx = -1; saw_step = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (bus.state == 2'b10) saw_step = 1;
            if (bus.state == 2'b01 && enter_idx < 0) enter_idx = i;
            if (bus.cpu_ce && ce_idx < 0) ce_idx = i;
            if (i == 10) bus.step_btn = 1'b0;
        end
        check_val("simul_run_entry", 32'(enter_idx), 32'd3);
        check_val("simul_first_ce_gap", 32'(ce_idx - enter_idx), 32'd4);
        check_val("simul_no_step", 32'(saw_step), 32'd0);
        $display("simul: run entered at +%0d, first ce at +%0d", enter_idx, ce_idx);

        // Reset asserted on the cycle a pulse falls due
        cur_tag = "rst_due";
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            if (m_mode == 1 && (m_cir % DIV) == DIV - 1) found = 1;
            else cycle();
        end
        if (found == 0) begin
            failures++;
            $display("FAIL rst_due_search: got no due point, want one within 16 cycles");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_due_ce", 32'(bus.cpu_ce), 32'd0);
        check_val("rst_due_tick", bus.tick_count, 32'd0);
        check_val("rst_due_state", 32'(bus.state), 32'd0);
        bus.run_sw = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        ce_cnt = 0;
        repeat (12) begin cycle(); ce_cnt += int'(bus.cpu_ce); end
        check_val("rst_no_ce_after", 32'(ce_cnt), 32'd0);
        $display("rst_due: reset on due point, ce after release=%0d", ce_cnt);

        // Release with run already requested: RUN after the synchronizer delay
        cur_tag = "rst_run";
        rst_n = 1'b0;
        model_reset();
        bus.run_sw = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check_val("rst_run_still_halt", 32'(bus.state), 32'd0);
        cycle();
        check_val("rst_run_entered", 32'(bus.state), 32'd1);
        $display("rst_run: state after release=%b", bus.state);

        // Tick counter wrap
        cur_tag = "wrap";
        force dut.tick_count_reg = 32'hFFFF_FFFF;
        release dut.tick_count_reg;
        m_tick = 32'hFFFF_FFFF;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            cycle();
            if (bus.cpu_ce) found = 1;
        end
        check_val("wrap_pulse_seen", 32'(found), 32'd1);
        cycle();
        check_val("wrap_tick", bus.tick_count, 32'd0);
        $display("wrap: tick after pulse=%h", bus.tick_count);

        // Random stimulus against the model
        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(59, 0) == 0) bus.run_sw = ~bus.run_sw;
            if ($urandom_range(11, 0) == 0) bus.step_btn = ~bus.step_btn;
            if ($urandom_range(99, 0) == 0) bus.bp_en = ~bus.bp_en;
            if ($urandom_range(7, 0) == 0)
                bus.pc_in = ($urandom_range(1, 0) == 0) ? 32'h10 : 32'($urandom);
            if ($urandom_range(799, 0) == 0) rst_n = 1'b0;
            else if (!rst_n) begin
                rst_n = 1'b1;
            end
            if (!rst_n) model_reset();
            cycle();
            if (i % 500 == 499)
                $display("random: %0d cycles, state=%b tick=%0d", i + 1, bus.state, bus.tick_count);
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DIVIDE_BY, default 5000000: clk100MHz cycles between cpu_ce pulses in RUN (legal range >=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: cycles step_btn must be stable before it is accepted (legal range >=1).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk100MHz  input  1  system clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 run_sw  input  1  raw run switch, asynchronous to clk100MHz; 1 = free-run requested.
REQ-007 step_btn  input  1  raw single-step push button, asynchronous and bouncing.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  32  breakpoint PC.
REQ-010 pc_in  input  32  current CPU PC, from the CPU debug PC output.
REQ-011 cpu_ce  output  1  one-cycle CPU clock-enable pulse; the CPU advances exactly one instruction per pulse.
REQ-012 state  output  2  current state: 00 HALT, 01 RUN, 10 STEP, 11 BREAK.
REQ-013 bp_hit  output  1  high while in BREAK.
REQ-014 tick_count  output  32  number of cpu_ce pulses issued since reset.

Function
REQ-015 run_sw and step_btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 Debounce: the debounced step level SHALL change only after the synchronized step_btn has held a new value for DEBOUNCE_CYCLES consecutive cycles; step_pulse SHALL be one cycle, on the debounced 0->1 edge only.
REQ-017 HALT: cpu_ce=0; run_sw_sync=1 -> RUN with the prescaler cleared to 0; otherwise step_pulse -> STEP; otherwise stay.
REQ-018 HALT priority: run_sw_sync and step_pulse in the same cycle -> RUN, and the step is discarded.
REQ-019 STEP: cpu_ce=1 for exactly that one cycle; the next state SHALL be HALT unconditionally, and the breakpoint is not checked.
REQ-020 RUN: the prescaler SHALL count 0..DIVIDE_BY-1 and wrap; a pulse is due on the cycle the prescaler equals DIVIDE_BY-1, so the first pulse comes DIVIDE_BY cycles after entry.
REQ-021 RUN, DIVIDE_BY=1: cpu_ce SHALL be due on every cycle in RUN.
REQ-022 Breakpoint: when a pulse is due, bp_en=1 and pc_in==bp_addr -> cpu_ce is suppressed and the next state is BREAK.
REQ-023 RUN: run_sw_sync=0 -> HALT, with no pulse issued that cycle, even if one is due; step_pulse is ignored in RUN.
REQ-024 BREAK: cpu_ce=0 and bp_hit=1; step_pulse -> STEP, which executes the breakpoint instruction.
REQ-025 BREAK: run_sw_sync=0 -> HALT; run_sw held at 1 SHALL NOT leave BREAK; run_sw_sync=0 has priority over step_pulse.
REQ-026 tick_count SHALL increment by 1 on each cycle cpu_ce=1 and wrap from FFFFFFFF to 00000000.
REQ-027 cpu_ce, state and bp_hit SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-028 rst_n=0 SHALL immediately force: state=HALT, cpu_ce=0, bp_hit=0, tick_count=0, prescaler=0, debounce counter=0, debounced step=0, all synchronizer flops=0.
REQ-029 Reset asserted mid-RUN or mid-STEP SHALL drop any pending pulse; after release, no cpu_ce until a new run or step request is seen.
REQ-030 After release, the block SHALL exit HALT only on inputs sampled after release; a run_sw already at 1 enters RUN after the 2-cycle synchronizer delay.

Verification (DIVIDE_BY=4, DEBOUNCE_CYCLES=8)
REQ-031 run_sw=1 held for 40 cycles, bp_en=0 -> RUN reached, cpu_ce pulses exactly 4 cycles apart, tick_count matches pulse count.
REQ-032 step_btn bouncing 0/1 every 3 cycles, then stable 1 for 8 cycles, then released -> exactly one cpu_ce, state HALT->STEP->HALT, tick_count +1.
REQ-033 bp_en=1, bp_addr=00000010, pc_in=00000010 while in RUN -> no cpu_ce at the due point, state=11, bp_hit=1; then a clean step press -> one cpu_ce, state returns to 00.
REQ-034 run_sw and the step edge arrive in the same cycle in HALT -> state=01, no STEP cycle, the first cpu_ce comes 4 cycles later.
REQ-035 rst_n=0 asserted on the cycle a pulse is due -> cpu_ce stays 0, tick_count=0, state=00; tick_count preloaded to FFFFFFFF via force -> the next pulse wraps it to 00000000.
